// File: rtl/flow_stat_pkg.sv
// rtl/flow_stat_pkg.sv - shared types and default widths for the per-flow statistics counter
package flow_stat_pkg;

  localparam int DEF_A_WIDTH    = 10;
  localparam int DEF_SIZE_WIDTH = 16;
  localparam int DEF_BCNT_WIDTH = 48;
  localparam int DEF_PCNT_WIDTH = 32;

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    IDLE     = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    RD_OUT   = 3'd4
  } state_t;

  // Counter entry at the default widths; the RAM word is {byte_cnt, pkt_cnt}.
  typedef struct packed {
    logic [DEF_BCNT_WIDTH-1:0] byte_cnt;
    logic [DEF_PCNT_WIDTH-1:0] pkt_cnt;
  } stat_entry_t;

endpackage

// File: rtl/ram_2port_1clk.sv
// rtl/ram_2port_1clk.sv - simple dual-port RAM, one write port, one registered read port, single clock
module ram_2port_1clk #(
  parameter int DATA_WIDTH = 80,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Read-first on an address collision; the user forwards around it.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      r_mem[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      r_rd_data <= r_mem[rd_addr_i];
    end
  end

  assign rd_data_o = r_rd_data;

endmodule

// File: rtl/flow_stat_cnt.sv
// rtl/flow_stat_cnt.sv - per-flow byte/packet counters with atomic read/read-and-clear
// Define STAT_SATURATE_EN to clamp counters at all-ones instead of wrapping.
module flow_stat_cnt
  import flow_stat_pkg::*;
#(
  parameter int A_WIDTH    = DEF_A_WIDTH,
  parameter int SIZE_WIDTH = DEF_SIZE_WIDTH,
  parameter int BCNT_WIDTH = DEF_BCNT_WIDTH,
  parameter int PCNT_WIDTH = DEF_PCNT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [A_WIDTH-1:0]    rx_flow_num_i,
  input  logic [SIZE_WIDTH-1:0] pkt_size_i,
  input  logic                  pkt_size_ena_i,
  input  logic                  rd_stb_i,
  input  logic [A_WIDTH-1:0]    rd_flow_num_i,
  input  logic                  rd_clear_i,
  output logic                  rd_busy_o,
  output logic [BCNT_WIDTH-1:0] rd_byte_cnt_o,
  output logic [PCNT_WIDTH-1:0] rd_pkt_cnt_o,
  output logic                  rd_data_val_o,
  output logic                  init_done_o
);

  localparam int DATA_WIDTH = BCNT_WIDTH + PCNT_WIDTH;
  localparam int BSUM_WIDTH = ((BCNT_WIDTH > SIZE_WIDTH) ? BCNT_WIDTH : SIZE_WIDTH) + 1;
  localparam logic [A_WIDTH-1:0] LAST_ADDR = '1;
`ifdef STAT_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  typedef struct packed {
    logic [BCNT_WIDTH-1:0] byte_cnt;
    logic [PCNT_WIDTH-1:0] pkt_cnt;
  } entry_t;

  state_t                r_state;
  logic [A_WIDTH-1:0]    r_init_addr;
  logic                  r_init_done;
  logic                  r_busy;
  logic                  r_data_val;
  logic [BCNT_WIDTH-1:0] r_rd_byte;
  logic [PCNT_WIDTH-1:0] r_rd_pkt;
  logic [A_WIDTH-1:0]    r_rd_flow;
  logic                  r_rd_clr;

  // Stage 1: RAM read in flight. A snapshot read rides the same slot as an update.
  logic                  r_s1_vld;
  logic                  r_s1_rd;
  logic                  r_s1_clr;
  logic [A_WIDTH-1:0]    r_s1_flow;
  logic [SIZE_WIDTH-1:0] r_s1_size;

  // Stage 2 result register, written to RAM next cycle; stage 3 keeps the word just written.
  logic                  r_s2_vld;
  logic [A_WIDTH-1:0]    r_s2_flow;
  entry_t                r_s2_data;
  logic                  r_s3_vld;
  logic [A_WIDTH-1:0]    r_s3_flow;
  entry_t                r_s3_data;

  logic                  w_upd;
  logic                  w_rd_issue;
  logic                  w_ram_re;
  logic [A_WIDTH-1:0]    w_ram_raddr;
  logic [DATA_WIDTH-1:0] w_ram_rdata_raw;
  entry_t                w_ram_rdata;
  logic                  w_ram_we;
  logic [A_WIDTH-1:0]    w_ram_waddr;
  logic [DATA_WIDTH-1:0] w_ram_wdata;
  entry_t                w_base;
  entry_t                w_next;
  logic [BSUM_WIDTH-1:0] w_byte_sum;
  logic [PCNT_WIDTH:0]   w_pkt_sum;
  logic                  w_byte_ovf;
  logic                  w_pkt_ovf;

  assign w_upd       = pkt_size_ena_i && r_init_done;
  assign w_rd_issue  = (r_state == RD_ISSUE) && !w_upd;
  assign w_ram_re    = w_upd || w_rd_issue;
  assign w_ram_raddr = w_upd ? rx_flow_num_i : r_rd_flow;
  assign w_ram_rdata = w_ram_rdata_raw;

  assign w_ram_we    = (r_state == INIT) || r_s2_vld;
  assign w_ram_waddr = (r_state == INIT) ? r_init_addr : r_s2_flow;
  assign w_ram_wdata = (r_state == INIT) ? '0 : r_s2_data;

  // The two most recent writes are not yet visible to a read issued alongside them.
  always_comb begin
    w_base = w_ram_rdata;
    if (r_s2_vld && (r_s2_flow == r_s1_flow)) begin
      w_base = r_s2_data;
    end else if (r_s3_vld && (r_s3_flow == r_s1_flow)) begin
      w_base = r_s3_data;
    end
  end

  assign w_byte_sum = {{(BSUM_WIDTH-BCNT_WIDTH){1'b0}}, w_base.byte_cnt}
                    + {{(BSUM_WIDTH-SIZE_WIDTH){1'b0}}, r_s1_size};
  assign w_pkt_sum  = {1'b0, w_base.pkt_cnt} + {{PCNT_WIDTH{1'b0}}, 1'b1};
  assign w_byte_ovf = |w_byte_sum[BSUM_WIDTH-1:BCNT_WIDTH];
  assign w_pkt_ovf  = w_pkt_sum[PCNT_WIDTH];

  assign w_next.byte_cnt = (SATURATE && w_byte_ovf) ? '1 : w_byte_sum[BCNT_WIDTH-1:0];
  assign w_next.pkt_cnt  = (SATURATE && w_pkt_ovf)  ? '1 : w_pkt_sum[PCNT_WIDTH-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1_vld  <= 1'b0;
      r_s1_rd   <= 1'b0;
      r_s1_clr  <= 1'b0;
      r_s1_flow <= '0;
      r_s1_size <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_flow <= '0;
      r_s2_data <= '0;
      r_s3_vld  <= 1'b0;
      r_s3_flow <= '0;
      r_s3_data <= '0;
    end else begin
      r_s1_vld  <= w_ram_re;
      r_s1_rd   <= !w_upd;
      r_s1_clr  <= r_rd_clr;
      r_s1_flow <= w_ram_raddr;
      r_s1_size <= pkt_size_i;
      // A clearing snapshot becomes an ordinary write of zero, so later updates merge onto it.
      r_s2_vld  <= r_s1_vld && (!r_s1_rd || r_s1_clr);
      r_s2_flow <= r_s1_flow;
      r_s2_data <= r_s1_rd ? '0 : w_next;
      r_s3_vld  <= r_s2_vld;
      r_s3_flow <= r_s2_flow;
      r_s3_data <= r_s2_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= INIT;
      r_init_addr <= '0;
      r_init_done <= 1'b0;
      r_busy      <= 1'b1;
      r_data_val  <= 1'b0;
      r_rd_byte   <= '0;
      r_rd_pkt    <= '0;
      r_rd_flow   <= '0;
      r_rd_clr    <= 1'b0;
    end else begin
      r_data_val <= 1'b0;
      case (r_state)
        INIT: begin
          r_init_addr <= r_init_addr + 1'b1;
          if (r_init_addr == LAST_ADDR) begin
            r_state     <= IDLE;
            r_init_done <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        IDLE: begin
          if (rd_stb_i) begin
            r_rd_flow <= rd_flow_num_i;
            r_rd_clr  <= rd_clear_i;
            r_busy    <= 1'b1;
            r_state   <= RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          if (!w_upd) begin
            r_state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          r_rd_byte  <= w_base.byte_cnt;
          r_rd_pkt   <= w_base.pkt_cnt;
          r_data_val <= 1'b1;
          r_state    <= RD_OUT;
        end
        RD_OUT: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state     <= INIT;
          r_init_addr <= '0;
          r_init_done <= 1'b0;
          r_busy      <= 1'b1;
        end
      endcase
    end
  end

  ram_2port_1clk #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (A_WIDTH)
  ) u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (w_ram_we),
    .wr_addr_i (w_ram_waddr),
    .wr_data_i (w_ram_wdata),
    .rd_en_i   (w_ram_re),
    .rd_addr_i (w_ram_raddr),
    .rd_data_o (w_ram_rdata_raw)
  );

  assign rd_busy_o     = r_busy;
  assign rd_byte_cnt_o = r_rd_byte;
  assign rd_pkt_cnt_o  = r_rd_pkt;
  assign rd_data_val_o = r_data_val;
  assign init_done_o   = r_init_done;

endmodule

// File: tb/tb_flow_stat_cnt.sv
// tb/tb_flow_stat_cnt.sv - directed self-checking bench for flow_stat_cnt (default and 12-bit byte counter instances)
module tb_flow_stat_cnt;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0]  flow, rd_flow;
  logic [15:0] size;
  logic        ena, stb, clr;
  logic        busy, val, done;
  logic [47:0] bcnt;
  logic [31:0] pcnt;

  logic [3:0]  flow_w, rd_flow_w;
  logic [15:0] size_w;
  logic        ena_w, stb_w, clr_w;
  logic        busy_w, val_w, done_w;
  logic [11:0] bcnt_w;
  logic [31:0] pcnt_w;

  int n_checks = 0;
  int n_fail   = 0;

  flow_stat_cnt u_dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rx_flow_num_i  (flow),
    .pkt_size_i     (size),
    .pkt_size_ena_i (ena),
    .rd_stb_i       (stb),
    .rd_flow_num_i  (rd_flow),
    .rd_clear_i     (clr),
    .rd_busy_o      (busy),
    .rd_byte_cnt_o  (bcnt),
    .rd_pkt_cnt_o   (pcnt),
    .rd_data_val_o  (val),
    .init_done_o    (done)
  );

  flow_stat_cnt #(
    .A_WIDTH    (4),
    .SIZE_WIDTH (16),
    .BCNT_WIDTH (12),
    .PCNT_WIDTH (32)
  ) u_dut_w (
    .clk_i          (clk),
    .rst_i          (rst),
    .rx_flow_num_i  (flow_w),
    .pkt_size_i     (size_w),
    .pkt_size_ena_i (ena_w),
    .rd_stb_i       (stb_w),
    .rd_flow_num_i  (rd_flow_w),
    .rd_clear_i     (clr_w),
    .rd_busy_o      (busy_w),
    .rd_byte_cnt_o  (bcnt_w),
    .rd_pkt_cnt_o   (pcnt_w),
    .rd_data_val_o  (val_w),
    .init_done_o    (done_w)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_upd(input bit w, input int f, input int s, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (w) begin ena_w = 1'b1; flow_w = f[3:0]; size_w = s[15:0]; end
      else   begin ena   = 1'b1; flow   = f[9:0]; size   = s[15:0]; end
    end
    @(negedge clk);
    ena   = 1'b0;
    ena_w = 1'b0;
  endtask

  task automatic do_read(input bit w, input int f, input bit c,
                         output logic [63:0] b, output logic [63:0] p, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while ((w ? busy_w : busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("rd_ready", 64'(n < 3000), 64'd1);
    if (w) begin stb_w = 1'b1; rd_flow_w = f[3:0]; clr_w = c; end
    else   begin stb   = 1'b1; rd_flow   = f[9:0]; clr   = c; end
    @(negedge clk);
    stb   = 1'b0;
    stb_w = 1'b0;
    lat   = 1;
    while (!(w ? val_w : val) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("rd_val_seen", 64'(lat < 200), 64'd1);
    b = w ? 64'(bcnt_w) : 64'(bcnt);
    p = w ? 64'(pcnt_w) : 64'(pcnt);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] b, p, b2, p2;
    int lat, n, vcnt;
    bit got_snap;

    {ena, stb, clr, ena_w, stb_w, clr_w} = '0;
    flow = '0; rd_flow = '0; size = '0;
    flow_w = '0; rd_flow_w = '0; size_w = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_init_done", 64'(done), 64'd0);
    check("rst_data_val", 64'(val), 64'd0);
    check("rst_byte_cnt", 64'(bcnt), 64'd0);
    check("rst_pkt_cnt", 64'(pcnt), 64'd0);

    // Release and count init cycles; updates to flow 5 during init must be dropped.
    rst = 1'b0;
    n = 0;
    while (!done && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (n == 2)  begin ena = 1'b1; flow = 10'd5; size = 16'd77; end
      if (n == 12) ena = 1'b0;
    end
    check("init_cycles", 64'(n), 64'd1024);

    do_read(0, 5, 1'b0, b, p, lat);
    check("f5_bytes_after_init", b, 64'd0);
    check("f5_pkts_after_init", p, 64'd0);
    check("rd_latency", 64'(lat), 64'd3);

    do_upd(0, 3, 100, 10);
    do_read(0, 3, 1'b1, b, p, lat);
    check("f3_clr_bytes", b, 64'd1000);
    check("f3_clr_pkts", p, 64'd10);
    do_read(0, 3, 1'b0, b, p, lat);
    check("f3_after_clr_bytes", b, 64'd0);
    check("f3_after_clr_pkts", p, 64'd0);

    do_upd(0, 7, 1500, 4);
    do_read(0, 7, 1'b0, b, p, lat);
    check("f7_ro_bytes", b, 64'd6000);
    check("f7_ro_pkts", p, 64'd4);
    do_read(0, 7, 1'b0, b, p, lat);
    check("f7_ro2_bytes", b, 64'd6000);
    check("f7_ro2_pkts", p, 64'd4);

    // Continuous alternating burst with a read-and-clear of flow 1 requested mid-burst.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ena  = 1'b1;
      flow = (i % 2 == 0) ? 10'd1 : 10'd2;
      size = 16'd64;
      if (i == 40) begin stb = 1'b1; rd_flow = 10'd1; clr = 1'b1; end
      if (i == 41) stb = 1'b0;
    end
    @(negedge clk);
    ena = 1'b0;
    n = 0;
    while (!val && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("burst_rd_val", 64'(n < 200), 64'd1);
    b = 64'(bcnt);
    p = 64'(pcnt);
    do_read(0, 1, 1'b0, b2, p2, lat);
    check("burst_f1_sum_bytes", b + b2, 64'd3200);
    check("burst_f1_sum_pkts", p + p2, 64'd50);

    // Gapped updates to flow 9; the clear issues in the first gap after acceptance.
    // A second strobe while busy (flow 2, clear) must be ignored.
    got_snap = 1'b0;
    b = '0;
    p = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (val) begin got_snap = 1'b1; b = 64'(bcnt); p = 64'(pcnt); end
      ena  = (i % 3 != 2);
      flow = 10'd9;
      size = 16'd10;
      if (i == 20) begin stb = 1'b1; rd_flow = 10'd9; clr = 1'b1; end
      if (i == 21) stb = 1'b0;
      if (i == 22) begin stb = 1'b1; rd_flow = 10'd2; clr = 1'b1; end
      if (i == 23) stb = 1'b0;
    end
    @(negedge clk);
    ena = 1'b0;
    check("gap_snap_seen", 64'(got_snap), 64'd1);
    check("gap_snap_bytes", b, 64'd160);
    check("gap_snap_pkts", p, 64'd16);
    do_read(0, 9, 1'b0, b, p, lat);
    check("gap_rest_bytes", b, 64'd240);
    check("gap_rest_pkts", p, 64'd24);
    do_read(0, 2, 1'b0, b, p, lat);
    check("busy_stb_ignored_bytes", b, 64'd3200);
    check("busy_stb_ignored_pkts", p, 64'd50);

    do_upd(1, 2, 2000, 3);
    do_read(1, 2, 1'b0, b, p, lat);
`ifdef STAT_SATURATE_EN
    check("narrow_bytes_sat", b, 64'd4095);
`else
    check("narrow_bytes_wrap", b, 64'd1904);
`endif
    check("narrow_pkts", p, 64'd3);

    // Reset asserted while the read of flow 7 sits in RD_WAIT.
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    stb = 1'b1; rd_flow = 10'd7; clr = 1'b0;
    @(negedge clk);
    stb = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrd_rst_busy", 64'(busy), 64'd1);
    check("midrd_rst_done", 64'(done), 64'd0);
    vcnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (val) vcnt++;
    end
    rst = 1'b0;
    n = 0;
    while (!done && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (val) vcnt++;
    end
    check("reinit_cycles", 64'(n), 64'd1024);
    check("midrd_no_val", 64'(vcnt), 64'd0);
    do_read(0, 7, 1'b0, b, p, lat);
    check("reinit_f7_bytes", b, 64'd0);
    check("reinit_f7_pkts", p, 64'd0);
    do_read(0, 2, 1'b0, b, p, lat);
    check("reinit_f2_bytes", b, 64'd0);
    do_read(0, 9, 1'b0, b, p, lat);
    check("reinit_f9_pkts", p, 64'd0);
    do_read(1, 2, 1'b0, b, p, lat);
    check("reinit_narrow_bytes", b, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
